// File: rtl/led_seq_pkg.sv
// Shared mode codes, initial patterns and control FSM encoding for led_sequencer.
// No logic of its own; init_pattern() maps a mode code to its first animation frame.
package led_seq_pkg;

   localparam logic [2:0] MODE_OFF    = 3'd0;
   localparam logic [2:0] MODE_ALL_ON = 3'd1;
   localparam logic [2:0] MODE_CHASE  = 3'd2;
   localparam logic [2:0] MODE_BOUNCE = 3'd3;
   localparam logic [2:0] MODE_BLINK  = 3'd4;
   localparam logic [2:0] MODE_BINARY = 3'd5;

   localparam logic [3:0] INIT_OFF    = 4'b0000;
   localparam logic [3:0] INIT_ALL_ON = 4'b1111;
   localparam logic [3:0] INIT_CHASE  = 4'b0001;
   localparam logic [3:0] INIT_BOUNCE = 4'b0001;
   localparam logic [3:0] INIT_BLINK  = 4'b1111;
   localparam logic [3:0] INIT_BINARY = 4'b0000;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   // Reserved codes fall through to the OFF frame.
   function automatic logic [3:0] init_pattern(input logic [2:0] m);
      case (m)
         MODE_ALL_ON: init_pattern = INIT_ALL_ON;
         MODE_CHASE:  init_pattern = INIT_CHASE;
         MODE_BOUNCE: init_pattern = INIT_BOUNCE;
         MODE_BLINK:  init_pattern = INIT_BLINK;
         MODE_BINARY: init_pattern = INIT_BINARY;
         default:     init_pattern = INIT_OFF;
      endcase
   endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running divider: one-cycle tick every DIV clocks, first tick at cycle DIV-1 after reset.
// Latency: tick decoded combinationally from the count register. No backpressure.
module led_prescaler #(
   parameter int DIV = 3_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/led_sequencer.sv
// Four-LED animation sequencer, six modes, mode switches applied only on prescaler ticks.
// Latency: new pattern 1..DIV cycles after accept, plus 1; mode_ready low from accept until after the applying tick.
// Optional LED_SEQ_PWM_EN adds a brightness port and 16-step PWM dimming on the registered LED drives.
module led_sequencer
   import led_seq_pkg::*;
#(
   parameter int DIV = 3_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] mode,
   input  logic       mode_valid,
`ifdef LED_SEQ_PWM_EN
   input  logic [3:0] brightness,
`endif
   output logic       mode_ready,
   output logic       D1,
   output logic       D2,
   output logic       D3,
   output logic       D4
);

   state_t     state, state_nxt;
   logic [2:0] cur_mode, cur_mode_nxt;
   logic [2:0] pend_mode, pend_mode_nxt;
   logic [3:0] pattern, pattern_nxt;
   logic       dir, dir_nxt;
   logic       tick;

   led_prescaler #(.DIV(DIV)) u_presc (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign mode_ready = (state == ST_RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         cur_mode  <= MODE_OFF;
         pend_mode <= MODE_OFF;
         pattern   <= INIT_OFF;
         dir       <= DIR_UP;
      end else begin
         state     <= state_nxt;
         cur_mode  <= cur_mode_nxt;
         pend_mode <= pend_mode_nxt;
         pattern   <= pattern_nxt;
         dir       <= dir_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cur_mode_nxt  = cur_mode;
      pend_mode_nxt = pend_mode;
      pattern_nxt   = pattern;
      dir_nxt       = dir;
      case (state)
         ST_RUN: begin
            // A tick coincident with an accept still advances the old mode.
            if (tick) begin
               case (cur_mode)
                  MODE_CHASE:  pattern_nxt = {pattern[2:0], pattern[3]};
                  MODE_BOUNCE: begin
                     if (dir == DIR_UP) begin
                        if (pattern[3]) begin
                           pattern_nxt = pattern >> 1;
                           dir_nxt     = DIR_DOWN;
                        end else begin
                           pattern_nxt = pattern << 1;
                        end
                     end else begin
                        if (pattern[0]) begin
                           pattern_nxt = pattern << 1;
                           dir_nxt     = DIR_UP;
                        end else begin
                           pattern_nxt = pattern >> 1;
                        end
                     end
                  end
                  MODE_BLINK:  pattern_nxt = ~pattern;
                  MODE_BINARY: pattern_nxt = pattern + 4'd1;
                  default:     pattern_nxt = pattern;
               endcase
            end
            if (mode_valid) begin
               pend_mode_nxt = mode;
               state_nxt     = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (tick) begin
               cur_mode_nxt = pend_mode;
               pattern_nxt  = init_pattern(pend_mode);
               dir_nxt      = DIR_UP;
               state_nxt    = ST_RUN;
            end
         end
         default: state_nxt = ST_RUN;
      endcase
   end

`ifdef LED_SEQ_PWM_EN
   logic [3:0] pwm_cnt;
   logic [3:0] led_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt <= '0;
         led_q   <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 4'd1;
         led_q   <= pattern_nxt & {4{pwm_cnt < brightness}};
      end
   end

   assign {D4, D3, D2, D1} = led_q;
`else
   assign {D4, D3, D2, D1} = pattern;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with DIV = 4; phase tracks the prescaler count in the current cycle.
// Build with LED_SEQ_PWM_EN to exercise the dimming stage instead of the animation sequence.
module tb_led_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] mode;
   logic       mode_valid;
   logic       mode_ready;
   logic       D1, D2, D3, D4;
`ifdef LED_SEQ_PWM_EN
   logic [3:0] brightness;
`endif

   int errors = 0;
   int checks = 0;
   int phase  = 0;

   always #5 clk = ~clk;

   led_sequencer #(.DIV(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .mode_valid (mode_valid),
`ifdef LED_SEQ_PWM_EN
      .brightness (brightness),
`endif
      .mode_ready (mode_ready),
      .D1         (D1),
      .D2         (D2),
      .D3         (D3),
      .D4         (D4)
   );

   function automatic logic [3:0] dv();
      return {D4, D3, D2, D1};
   endfunction

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   // Advance n clocks; inputs change and outputs are sampled 1ns after the edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         phase = (phase + 1) % 4;
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      step(n);
      rst   = 1'b0;
      phase = 0;
   endtask

   // Issue a request in the current cycle and wait for it to be applied (request made at phase 0).
   task automatic request_at_phase0(input logic [2:0] m);
      mode       = m;
      mode_valid = 1'b1;
      chk("req_ready", {3'b0, mode_ready}, 4'b0001);
      step(1);
      mode_valid = 1'b0;
      chk("pend_ready_low", {3'b0, mode_ready}, 4'b0000);
      step(3);
      chk("applied_ready", {3'b0, mode_ready}, 4'b0001);
   endtask

`ifdef LED_SEQ_PWM_EN
   int on_cnt [4];
`endif

   initial begin
      logic [3:0] bounce_exp [8];
      bounce_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                     4'b0100, 4'b0010, 4'b0001, 4'b0010};
      mode       = 3'd0;
      mode_valid = 1'b0;
`ifdef LED_SEQ_PWM_EN
      brightness = 4'd0;
`endif
      step(1);
      do_reset(3);

      for (int i = 0; i < 20; i++) begin
         chk("reset_d", dv(), 4'b0000);
         chk("reset_ready", {3'b0, mode_ready}, 4'b0001);
         step(1);
      end

`ifdef LED_SEQ_PWM_EN
      brightness = 4'd4;
      request_at_phase0(3'd1);
      step(2);
      for (int k = 0; k < 4; k++) on_cnt[k] = 0;
      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < 4; k++) on_cnt[k] += int'(dv()[k]);
         step(1);
      end
      for (int k = 0; k < 4; k++) chk("pwm_b4_count", 4'(on_cnt[k]), 4'd4);

      brightness = 4'd0;
      step(2);
      for (int k = 0; k < 4; k++) on_cnt[k] = 0;
      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < 4; k++) on_cnt[k] += int'(dv()[k]);
         step(1);
      end
      for (int k = 0; k < 4; k++) chk("pwm_b0_count", 4'(on_cnt[k]), 4'd0);
`else
      // CHASE: request at phase 0, applied by the tick three cycles later.
      mode       = 3'd2;
      mode_valid = 1'b1;
      step(1);
      mode_valid = 1'b0;
      chk("chase_ready_a1", {3'b0, mode_ready}, 4'b0000);
      step(2);
      chk("chase_ready_tickcyc", {3'b0, mode_ready}, 4'b0000);
      chk("chase_d_before", dv(), 4'b0000);
      step(1);
      chk("chase_ready_after", {3'b0, mode_ready}, 4'b0001);
      chk("chase_d0", dv(), 4'b0001);
      step(4); chk("chase_d1", dv(), 4'b0010);
      step(4); chk("chase_d2", dv(), 4'b0100);
      step(4); chk("chase_d3", dv(), 4'b1000);
      step(4); chk("chase_wrap", dv(), 4'b0001);

      // BOUNCE
      request_at_phase0(3'd3);
      chk("bounce_0", dv(), bounce_exp[0]);
      for (int i = 1; i < 8; i++) begin
         step(4);
         chk("bounce_seq", dv(), bounce_exp[i]);
      end

      // BINARY then ALL_ON accepted in the tick cycle.
      request_at_phase0(3'd5);
      chk("binary_0", dv(), 4'b0000);
      step(4); chk("binary_1", dv(), 4'b0001);
      step(4); chk("binary_2", dv(), 4'b0010);
      step(3);
      mode       = 3'd1;
      mode_valid = 1'b1;
      chk("coinc_ready", {3'b0, mode_ready}, 4'b0001);
      step(1);
      mode_valid = 1'b0;
      chk("coinc_extra_inc", dv(), 4'b0011);
      chk("coinc_ready_low", {3'b0, mode_ready}, 4'b0000);
      step(3);
      chk("coinc_still_binary", dv(), 4'b0011);
      step(1);
      chk("coinc_all_on", dv(), 4'b1111);
      chk("coinc_ready_back", {3'b0, mode_ready}, 4'b0001);
      step(4);
      chk("all_on_held", dv(), 4'b1111);

      // Reset while PENDING a BLINK request.
      mode       = 3'd4;
      mode_valid = 1'b1;
      step(1);
      mode_valid = 1'b0;
      chk("rstpend_ready_low", {3'b0, mode_ready}, 4'b0000);
      step(1);
      do_reset(1);
      chk("rstpend_d", dv(), 4'b0000);
      chk("rstpend_ready", {3'b0, mode_ready}, 4'b0001);
      for (int i = 0; i < 12; i++) begin
         step(1);
         chk("rstpend_no_blink", dv(), 4'b0000);
         chk("rstpend_ready_hold", {3'b0, mode_ready}, 4'b0001);
      end

      // BLINK, re-request restart, reserved code behaves as OFF.
      request_at_phase0(3'd4);
      chk("blink_0", dv(), 4'b1111);
      step(4); chk("blink_1", dv(), 4'b0000);
      request_at_phase0(3'd4);
      chk("blink_restart", dv(), 4'b1111);
      step(4); chk("blink_restart_1", dv(), 4'b0000);
      request_at_phase0(3'd7);
      chk("reserved_0", dv(), 4'b0000);
      step(4); chk("reserved_held", dv(), 4'b0000);

      // Request ignored while not ready.
      mode       = 3'd1;
      mode_valid = 1'b1;
      step(1);
      mode       = 3'd2;
      step(3);
      mode_valid = 1'b0;
      chk("ignored_while_busy", dv(), 4'b1111);
      step(4);
      chk("ignored_held", dv(), 4'b1111);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
